// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcode/func fields,
// ALU operation codes, mux selects, FSM states and instruction classes.
package multicycle_control_pkg;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OPCODE_RTYPE = 6'h00;
   localparam logic [5:0] OPCODE_J     = 6'h02;
   localparam logic [5:0] OPCODE_JAL   = 6'h03;
   localparam logic [5:0] OPCODE_BEQ   = 6'h04;
   localparam logic [5:0] OPCODE_BNE   = 6'h05;
   localparam logic [5:0] OPCODE_ADDI  = 6'h08;
   localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
   localparam logic [5:0] OPCODE_ORI   = 6'h0D;
   localparam logic [5:0] OPCODE_LW    = 6'h23;
   localparam logic [5:0] OPCODE_SW    = 6'h2B;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FUNC_SLL = 6'h00;
   localparam logic [5:0] FUNC_SRL = 6'h02;
   localparam logic [5:0] FUNC_ADD = 6'h20;
   localparam logic [5:0] FUNC_SUB = 6'h22;
   localparam logic [5:0] FUNC_AND = 6'h24;
   localparam logic [5:0] FUNC_OR  = 6'h25;
   localparam logic [5:0] FUNC_NOR = 6'h27;
   localparam logic [5:0] FUNC_SLT = 6'h2A;

   // ALU operations
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_NOR = 3'd4;
   localparam logic [2:0] OP_SLT = 3'd5;
   localparam logic [2:0] OP_SLL = 3'd6;
   localparam logic [2:0] OP_SRL = 3'd7;

   // ALU second operand select
   localparam logic ALU_SRC_DATA_B = 1'b0;
   localparam logic ALU_SRC_IMM16  = 1'b1;

   // PC next-value select
   localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
   localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
   localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

   // Link register written by JAL
   localparam logic [4:0] REG_RA = 5'd31;

   typedef enum logic [2:0] {
      STATE_FETCH  = 3'd0,
      STATE_DECODE = 3'd1,
      STATE_EXEC   = 3'd2,
      STATE_MEM    = 3'd3,
      STATE_WB     = 3'd4
   } state_t;

   typedef enum logic [3:0] {
      CLS_ILLEGAL = 4'd0,
      CLS_ALU_R   = 4'd1,
      CLS_ALU_I   = 4'd2,
      CLS_LW      = 4'd3,
      CLS_SW      = 4'd4,
      CLS_BEQ     = 4'd5,
      CLS_BNE     = 4'd6,
      CLS_J       = 4'd7,
      CLS_JAL     = 4'd8
   } instr_class_t;

endpackage

// File: rtl/multicycle_control_instr_decode.sv
// Combinational instruction classifier: opcode/func -> instruction class,
// ALU operation, ALU operand select, destination field select, illegal flag.
module multicycle_control_instr_decode
   import multicycle_control_pkg::*;
(
   input  logic [5:0]   i_opcode,
   input  logic [5:0]   i_func,
   output instr_class_t o_cls,
   output logic [2:0]   o_alu_op,
   output logic         o_alu_src,
   output logic         o_dest_rd,
   output logic         o_illegal
);

   // Classify the instruction; anything not listed is reported illegal
   always_comb begin
      o_cls     = CLS_ILLEGAL;
      o_alu_op  = OP_ADD;
      o_alu_src = ALU_SRC_DATA_B;
      o_dest_rd = 1'b0;
      case (i_opcode)
         OPCODE_RTYPE: begin
            o_dest_rd = 1'b1;
            o_cls     = CLS_ALU_R;
            case (i_func)
               FUNC_ADD: o_alu_op = OP_ADD;
               FUNC_SUB: o_alu_op = OP_SUB;
               FUNC_AND: o_alu_op = OP_AND;
               FUNC_OR:  o_alu_op = OP_OR;
               FUNC_NOR: o_alu_op = OP_NOR;
               FUNC_SLT: o_alu_op = OP_SLT;
               FUNC_SLL: o_alu_op = OP_SLL;
               FUNC_SRL: o_alu_op = OP_SRL;
               default:  o_cls    = CLS_ILLEGAL;
            endcase
         end
         OPCODE_ADDI: begin
            o_cls     = CLS_ALU_I;
            o_alu_op  = OP_ADD;
            o_alu_src = ALU_SRC_IMM16;
         end
         OPCODE_ANDI: begin
            o_cls     = CLS_ALU_I;
            o_alu_op  = OP_AND;
            o_alu_src = ALU_SRC_IMM16;
         end
         OPCODE_ORI: begin
            o_cls     = CLS_ALU_I;
            o_alu_op  = OP_OR;
            o_alu_src = ALU_SRC_IMM16;
         end
         OPCODE_LW: begin
            o_cls     = CLS_LW;
            o_alu_op  = OP_ADD;
            o_alu_src = ALU_SRC_IMM16;
         end
         OPCODE_SW: begin
            o_cls     = CLS_SW;
            o_alu_op  = OP_ADD;
            o_alu_src = ALU_SRC_IMM16;
         end
         OPCODE_BEQ: begin
            o_cls    = CLS_BEQ;
            o_alu_op = OP_SUB;
         end
         OPCODE_BNE: begin
            o_cls    = CLS_BNE;
            o_alu_op = OP_SUB;
         end
         OPCODE_J:   o_cls = CLS_J;
         OPCODE_JAL: o_cls = CLS_JAL;
         default:    o_cls = CLS_ILLEGAL;
      endcase
      o_illegal = (o_cls == CLS_ILLEGAL);
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: owns the IR and sequences
// FETCH/DECODE/EXEC/MEM/WB with a req/ready memory handshake, a memory
// timeout and illegal-instruction reporting.
// Optional feature macro: MC_PERF_COUNT_EN adds cycle/instruction counters.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int ALU_OP_W    = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
)(
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic [31:0]         i_mem_rdata,
   input  logic                i_mem_ready,
   input  logic                i_alu_zero,
   output logic                o_mem_req,
   output logic                o_mem_we,
   output logic                o_iord,
   output logic                o_ir_write,
   output logic                o_pc_write,
   output logic [1:0]          o_pc_src,
   output logic                o_reg_write,
   output logic                o_mem_to_reg,
   output logic                o_alu_src,
   output logic [ALU_OP_W-1:0] o_alu_op,
   output logic [4:0]          o_addr_a,
   output logic [4:0]          o_addr_b,
   output logic [4:0]          o_addr_in,
   output logic [4:0]          o_shamt,
   output logic [15:0]         o_imm16,
   output logic [25:0]         o_addr26,
   output logic                o_illegal,
   output logic                o_mem_fault,
   output logic [2:0]          o_state
`ifdef MC_PERF_COUNT_EN
   ,
   output logic [CNT_W-1:0]    o_cycle_count,
   output logic [CNT_W-1:0]    o_instr_count
`endif
);

   // Wait counter only needs to reach MEM_TIMEOUT-1
   localparam int TO_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   state_t           r_state;
   logic [31:0]      r_ir;
   logic [TO_W-1:0]  r_wait_cnt;

   state_t           w_next;
   instr_class_t     w_cls;
   logic [2:0]       w_dec_alu_op;
   logic             w_dec_alu_src;
   logic             w_dest_rd;
   logic             w_dec_illegal;
   logic             w_to_hit;
   logic             w_mem_req, w_mem_we, w_iord, w_ir_write, w_pc_write;
   logic [1:0]       w_pc_src;
   logic             w_wb_req, w_mem_to_reg, w_alu_src, w_illegal, w_mem_fault;
   logic [2:0]       w_alu_op;
   logic [4:0]       w_addr_in;

   multicycle_control_instr_decode u_decode (
      .i_opcode  (r_ir[31:26]),
      .i_func    (r_ir[5:0]),
      .o_cls     (w_cls),
      .o_alu_op  (w_dec_alu_op),
      .o_alu_src (w_dec_alu_src),
      .o_dest_rd (w_dest_rd),
      .o_illegal (w_dec_illegal)
   );

   // Timeout fires on the MEM_TIMEOUT-th consecutive unanswered request cycle
   always_comb begin
      if (MEM_TIMEOUT != 0) begin
         w_to_hit = (r_wait_cnt == TO_W'(MEM_TIMEOUT - 1));
      end else begin
         w_to_hit = 1'b0;
      end
   end

   // Next-state and single-cycle strobe generation from state + IR
   always_comb begin
      w_next       = r_state;
      w_mem_req    = 1'b0;
      w_mem_we     = 1'b0;
      w_iord       = 1'b0;
      w_ir_write   = 1'b0;
      w_pc_write   = 1'b0;
      w_pc_src     = PC_SRC_PLUS4;
      w_wb_req     = 1'b0;
      w_mem_to_reg = 1'b0;
      w_alu_src    = ALU_SRC_DATA_B;
      w_alu_op     = OP_ADD;
      w_illegal    = 1'b0;
      w_mem_fault  = 1'b0;
      case (r_state)
         STATE_FETCH: begin
            w_mem_req = 1'b1;
            if (i_mem_ready) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_pc_src   = PC_SRC_PLUS4;
               w_next     = STATE_DECODE;
            end else if (w_to_hit) begin
               // Abandon the request; PC untouched so the same word is refetched
               w_mem_fault = 1'b1;
               w_next      = STATE_FETCH;
            end else begin
               w_next = STATE_FETCH;
            end
         end
         STATE_DECODE: begin
            case (w_cls)
               CLS_J: begin
                  w_pc_write = 1'b1;
                  w_pc_src   = PC_SRC_JUMP;
                  w_next     = STATE_FETCH;
               end
               CLS_JAL: begin
                  w_pc_write = 1'b1;
                  w_pc_src   = PC_SRC_JUMP;
                  w_wb_req   = 1'b1;
                  w_next     = STATE_FETCH;
               end
               CLS_ILLEGAL: begin
                  w_illegal = w_dec_illegal;
                  w_next    = STATE_FETCH;
               end
               default: w_next = STATE_EXEC;
            endcase
         end
         STATE_EXEC: begin
            w_alu_op  = w_dec_alu_op;
            w_alu_src = w_dec_alu_src;
            case (w_cls)
               CLS_BEQ: begin
                  w_pc_write = i_alu_zero;
                  w_pc_src   = PC_SRC_BRANCH;
                  w_next     = STATE_FETCH;
               end
               CLS_BNE: begin
                  w_pc_write = ~i_alu_zero;
                  w_pc_src   = PC_SRC_BRANCH;
                  w_next     = STATE_FETCH;
               end
               CLS_LW:  w_next = STATE_MEM;
               CLS_SW:  w_next = STATE_MEM;
               default: w_next = STATE_WB;
            endcase
         end
         STATE_MEM: begin
            w_mem_req = 1'b1;
            w_iord    = 1'b1;
            w_mem_we  = (w_cls == CLS_SW);
            if (i_mem_ready) begin
               w_next = (w_cls == CLS_SW) ? STATE_FETCH : STATE_WB;
            end else if (w_to_hit) begin
               w_mem_fault = 1'b1;
               w_next      = STATE_FETCH;
            end else begin
               w_next = STATE_MEM;
            end
         end
         STATE_WB: begin
            w_wb_req     = 1'b1;
            w_mem_to_reg = (w_cls == CLS_LW);
            w_next       = STATE_FETCH;
         end
         default: w_next = STATE_FETCH;
      endcase
   end

   // Destination register: r31 for JAL, rd for R-type, rt otherwise
   always_comb begin
      if (w_cls == CLS_JAL) begin
         w_addr_in = REG_RA;
      end else if (w_dest_rd) begin
         w_addr_in = r_ir[15:11];
      end else begin
         w_addr_in = r_ir[20:16];
      end
   end

   // State register and instruction register
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= STATE_FETCH;
         r_ir    <= 32'd0;
      end else begin
         r_state <= w_next;
         if (w_ir_write) begin
            r_ir <= i_mem_rdata;
         end
      end
   end

   // Wait-cycle counter: counts unanswered request cycles, clears otherwise
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wait_cnt <= '0;
      end else if ((MEM_TIMEOUT != 0) && w_mem_req && !i_mem_ready && !w_to_hit) begin
         r_wait_cnt <= r_wait_cnt + TO_W'(1);
      end else begin
         r_wait_cnt <= '0;
      end
   end

   // Drive ports; everything is held at zero while reset is asserted
   always_comb begin
      if (i_reset) begin
         o_mem_req    = 1'b0;
         o_mem_we     = 1'b0;
         o_iord       = 1'b0;
         o_ir_write   = 1'b0;
         o_pc_write   = 1'b0;
         o_pc_src     = 2'd0;
         o_reg_write  = 1'b0;
         o_mem_to_reg = 1'b0;
         o_alu_src    = 1'b0;
         o_alu_op     = '0;
         o_addr_a     = 5'd0;
         o_addr_b     = 5'd0;
         o_addr_in    = 5'd0;
         o_shamt      = 5'd0;
         o_imm16      = 16'd0;
         o_addr26     = 26'd0;
         o_illegal    = 1'b0;
         o_mem_fault  = 1'b0;
         o_state      = 3'd0;
      end else begin
         o_mem_req    = w_mem_req;
         o_mem_we     = w_mem_we;
         o_iord       = w_iord;
         o_ir_write   = w_ir_write;
         o_pc_write   = w_pc_write;
         o_pc_src     = w_pc_src;
         o_reg_write  = w_wb_req && (w_addr_in != 5'd0);
         o_mem_to_reg = w_mem_to_reg;
         o_alu_src    = w_alu_src;
         o_alu_op     = ALU_OP_W'(w_alu_op);
         o_addr_a     = r_ir[25:21];
         o_addr_b     = r_ir[20:16];
         o_addr_in    = w_addr_in;
         o_shamt      = r_ir[10:6];
         o_imm16      = r_ir[15:0];
         o_addr26     = r_ir[25:0];
         o_illegal    = w_illegal;
         o_mem_fault  = w_mem_fault;
         o_state      = r_state;
      end
   end

`ifdef MC_PERF_COUNT_EN
   logic [CNT_W-1:0] r_cycle_count;
   logic [CNT_W-1:0] r_instr_count;
   logic             w_instr_done;

   // An instruction completes when FETCH is re-entered other than by a fault
   assign w_instr_done = (r_state != STATE_FETCH) && (w_next == STATE_FETCH) && !w_mem_fault;

   // Free-running cycle counter and retired-instruction counter
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_cycle_count <= '0;
         r_instr_count <= '0;
      end else begin
         r_cycle_count <= r_cycle_count + CNT_W'(1);
         if (w_instr_done) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
         end
      end
   end

   assign o_cycle_count = r_cycle_count;
   assign o_instr_count = r_instr_count;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Table-driven bench for multicycle_control (MEM_TIMEOUT = 4).
// Each table row is one clock cycle: memory/ALU inputs plus the expected
// state and control outputs for that cycle.
module tb_multicycle_control;

   localparam logic       H = 1'b1;
   localparam logic       L = 1'b0;
   localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4;
   localparam logic [2:0] A_ADD = 3'd0, A_SUB = 3'd1, A_OR = 3'd3;
   localparam logic [1:0] P4 = 2'd0, PB = 2'd1, PJ = 2'd2;

   localparam logic [31:0] I_ADD  = 32'h00221820;  // add  r3,r1,r2
   localparam logic [31:0] I_LW   = 32'h8C850008;  // lw   r5,8(r4)
   localparam logic [31:0] I_BEQ  = 32'h10220004;  // beq  r1,r2,4
   localparam logic [31:0] I_ADDI = 32'h20200005;  // addi r0,r1,5
   localparam logic [31:0] I_BAD  = 32'hFC000000;  // opcode 0x3F
   localparam logic [31:0] I_J    = 32'h08000100;  // j
   localparam logic [31:0] I_JAL  = 32'h0C000040;  // jal
   localparam logic [31:0] I_SW   = 32'hACE60004;  // sw   r6,4(r7)
   localparam logic [31:0] I_ORI  = 32'h350900FF;  // ori  r9,r8,0xff
   localparam logic [31:0] I_SUB  = 32'h00225022;  // sub  r10,r1,r2
   localparam logic [31:0] I_BADF = 32'h0000003F;  // R-type, func 0x3F
   localparam logic [31:0] Z      = 32'h0;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        ready;
      logic        zero;
      logic [22:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_pass  = 0;
   int   n_total = 0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;
   logic        alu_zero = 1'b0;
   logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write, mem_to_reg, alu_src;
   logic        illegal, mem_fault;
   logic [1:0]  pc_src;
   logic [2:0]  alu_op, state;
   logic [4:0]  addr_a, addr_b, addr_in, shamt;
   logic [15:0] imm16;
   logic [25:0] addr26;
   logic [22:0] act;
   logic [56:0] fields;
`ifdef MC_PERF_COUNT_EN
   logic [31:0] cycle_count, instr_count;
`endif

   always #5 clk = ~clk;

   multicycle_control #(.ALU_OP_W(3), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_mem_rdata  (mem_rdata),
      .i_mem_ready  (mem_ready),
      .i_alu_zero   (alu_zero),
      .o_mem_req    (mem_req),
      .o_mem_we     (mem_we),
      .o_iord       (iord),
      .o_ir_write   (ir_write),
      .o_pc_write   (pc_write),
      .o_pc_src     (pc_src),
      .o_reg_write  (reg_write),
      .o_mem_to_reg (mem_to_reg),
      .o_alu_src    (alu_src),
      .o_alu_op     (alu_op),
      .o_addr_a     (addr_a),
      .o_addr_b     (addr_b),
      .o_addr_in    (addr_in),
      .o_shamt      (shamt),
      .o_imm16      (imm16),
      .o_addr26     (addr26),
      .o_illegal    (illegal),
      .o_mem_fault  (mem_fault),
      .o_state      (state)
`ifdef MC_PERF_COUNT_EN
      ,
      .o_cycle_count(cycle_count),
      .o_instr_count(instr_count)
`endif
   );

   assign act = {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                 reg_write, mem_to_reg, alu_src, alu_op, addr_in, illegal, mem_fault};
   assign fields = {addr_a, addr_b, shamt, imm16, addr26};

   function automatic logic [22:0] mk(input logic [2:0] st, input logic req, we, io, irw, pcw,
                                      input logic [1:0] pcs, input logic rw, m2r, asrc,
                                      input logic [2:0] aop, input logic [4:0] ain,
                                      input logic ill, flt);
      return {st, req, we, io, irw, pcw, pcs, rw, m2r, asrc, aop, ain, ill, flt};
   endfunction

   task automatic add(input string n, input logic [31:0] rd, input logic rdy, input logic z,
                      input logic [22:0] e);
      vec_t v;
      v.name = n; v.rdata = rd; v.ready = rdy; v.zero = z; v.exp = e;
      vecs.push_back(v);
   endtask

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      n_total++;
      if (a !== e) begin
         $display("FAIL %s: actual=%h required=%h", n, a, e);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      // ADD r3,r1,r2: 4 cycles, WB writes r3
      add("add_f",   I_ADD, H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd0,L,L));
      add("add_d",   Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd3,L,L));
      add("add_e",   Z,     H, L, mk(S_E,L,L,L,L,L,P4,L,L,L,A_ADD,5'd3,L,L));
      add("add_w",   Z,     H, L, mk(S_W,L,L,L,L,L,P4,H,L,L,A_ADD,5'd3,L,L));
      // LW r5,8(r4) with two MEM wait cycles: 7 cycles total
      add("lw_f",    I_LW,  H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd3,L,L));
      add("lw_d",    Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lw_e",    Z,     H, L, mk(S_E,L,L,L,L,L,P4,L,L,H,A_ADD,5'd5,L,L));
      add("lw_m1",   Z,     L, L, mk(S_M,H,L,H,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lw_m2",   Z,     L, L, mk(S_M,H,L,H,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lw_m3",   Z,     H, L, mk(S_M,H,L,H,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lw_w",    Z,     H, L, mk(S_W,L,L,L,L,L,P4,H,H,L,A_ADD,5'd5,L,L));
      // BEQ taken, then not taken
      add("beq1_f",  I_BEQ, H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd5,L,L));
      add("beq1_d",  Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd2,L,L));
      add("beq1_e",  Z,     H, H, mk(S_E,L,L,L,L,H,PB,L,L,L,A_SUB,5'd2,L,L));
      add("beq0_f",  I_BEQ, H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd2,L,L));
      add("beq0_d",  Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd2,L,L));
      add("beq0_e",  Z,     H, L, mk(S_E,L,L,L,L,L,PB,L,L,L,A_SUB,5'd2,L,L));
      // ADDI r0,r1,5: write to r0 suppressed
      add("addi_f",  I_ADDI,H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd2,L,L));
      add("addi_d",  Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd0,L,L));
      add("addi_e",  Z,     H, L, mk(S_E,L,L,L,L,L,P4,L,L,H,A_ADD,5'd0,L,L));
      add("addi_w",  Z,     H, L, mk(S_W,L,L,L,L,L,P4,L,L,L,A_ADD,5'd0,L,L));
      // Illegal opcode: one-cycle pulse in DECODE, back to FETCH
      add("bad_f",   I_BAD, H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd0,L,L));
      add("bad_d",   Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd0,H,L));
      // J and JAL: 2 cycles
      add("j_f",     I_J,   H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd0,L,L));
      add("j_d",     Z,     H, L, mk(S_D,L,L,L,L,H,PJ,L,L,L,A_ADD,5'd0,L,L));
      add("jal_f",   I_JAL, H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd0,L,L));
      add("jal_d",   Z,     H, L, mk(S_D,L,L,L,L,H,PJ,H,L,L,A_ADD,5'd31,L,L));
      // SW r6,4(r7) with one MEM wait cycle
      add("sw_f",    I_SW,  H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd31,L,L));
      add("sw_d",    Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd6,L,L));
      add("sw_e",    Z,     H, L, mk(S_E,L,L,L,L,L,P4,L,L,H,A_ADD,5'd6,L,L));
      add("sw_m1",   Z,     L, L, mk(S_M,H,H,H,L,L,P4,L,L,L,A_ADD,5'd6,L,L));
      add("sw_m2",   Z,     H, L, mk(S_M,H,H,H,L,L,P4,L,L,L,A_ADD,5'd6,L,L));
      // ORI r9,r8,0xff
      add("ori_f",   I_ORI, H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd6,L,L));
      add("ori_d",   Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd9,L,L));
      add("ori_e",   Z,     H, L, mk(S_E,L,L,L,L,L,P4,L,L,H,A_OR, 5'd9,L,L));
      add("ori_w",   Z,     H, L, mk(S_W,L,L,L,L,L,P4,H,L,L,A_ADD,5'd9,L,L));
      // FETCH timeout on the 4th unanswered cycle, then refetch (SUB)
      add("fto_w1",  Z,     L, L, mk(S_F,H,L,L,L,L,P4,L,L,L,A_ADD,5'd9,L,L));
      add("fto_w2",  Z,     L, L, mk(S_F,H,L,L,L,L,P4,L,L,L,A_ADD,5'd9,L,L));
      add("fto_w3",  Z,     L, L, mk(S_F,H,L,L,L,L,P4,L,L,L,A_ADD,5'd9,L,L));
      add("fto_w4",  Z,     L, L, mk(S_F,H,L,L,L,L,P4,L,L,L,A_ADD,5'd9,L,H));
      add("sub_f",   I_SUB, H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd9,L,L));
      add("sub_d",   Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd10,L,L));
      add("sub_e",   Z,     H, L, mk(S_E,L,L,L,L,L,P4,L,L,L,A_SUB,5'd10,L,L));
      add("sub_w",   Z,     H, L, mk(S_W,L,L,L,L,L,P4,H,L,L,A_ADD,5'd10,L,L));
      // LW: ready arrives on the would-be timeout cycle, ready wins
      add("lwr_f",   I_LW,  H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd10,L,L));
      add("lwr_d",   Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lwr_e",   Z,     H, L, mk(S_E,L,L,L,L,L,P4,L,L,H,A_ADD,5'd5,L,L));
      add("lwr_m1",  Z,     L, L, mk(S_M,H,L,H,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lwr_m2",  Z,     L, L, mk(S_M,H,L,H,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lwr_m3",  Z,     L, L, mk(S_M,H,L,H,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lwr_m4",  Z,     H, L, mk(S_M,H,L,H,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lwr_w",   Z,     H, L, mk(S_W,L,L,L,L,L,P4,H,H,L,A_ADD,5'd5,L,L));
      // LW: MEM timeout, back to FETCH without pc_write
      add("lwt_f",   I_LW,  H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lwt_d",   Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lwt_e",   Z,     H, L, mk(S_E,L,L,L,L,L,P4,L,L,H,A_ADD,5'd5,L,L));
      add("lwt_m1",  Z,     L, L, mk(S_M,H,L,H,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lwt_m2",  Z,     L, L, mk(S_M,H,L,H,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lwt_m3",  Z,     L, L, mk(S_M,H,L,H,L,L,P4,L,L,L,A_ADD,5'd5,L,L));
      add("lwt_m4",  Z,     L, L, mk(S_M,H,L,H,L,L,P4,L,L,L,A_ADD,5'd5,L,H));
      add("add2_f",  I_ADD, H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd5,L,L));
      add("add2_d",  Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd3,L,L));
      add("add2_e",  Z,     H, L, mk(S_E,L,L,L,L,L,P4,L,L,L,A_ADD,5'd3,L,L));
      add("add2_w",  Z,     H, L, mk(S_W,L,L,L,L,L,P4,H,L,L,A_ADD,5'd3,L,L));
      // R-type with unsupported func is illegal too
      add("badf_f",  I_BADF,H, L, mk(S_F,H,L,L,H,H,P4,L,L,L,A_ADD,5'd3,L,L));
      add("badf_d",  Z,     H, L, mk(S_D,L,L,L,L,L,P4,L,L,L,A_ADD,5'd0,H,L));

      // Reset state: everything zero
      repeat (2) @(negedge clk);
      #1;
      chk("reset_ctrl", 64'(act), 64'd0);
      chk("reset_fields", 64'(fields), 64'd0);
`ifdef MC_PERF_COUNT_EN
      chk("reset_counters", {cycle_count, instr_count}, 64'd0);
`endif
      reset = 1'b0;

      // Table: one row per cycle
      for (int i = 0; i < vecs.size(); i++) begin
         mem_rdata = vecs[i].rdata;
         mem_ready = vecs[i].ready;
         alu_zero  = vecs[i].zero;
         #1;
         chk(vecs[i].name, 64'(act), 64'(vecs[i].exp));
         @(negedge clk);
      end

      // Field extraction in DECODE of SW r6,4(r7)
      mem_rdata = I_SW;
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
      chk("sw_fields", 64'(fields), 64'({5'd7, 5'd6, 5'd0, 16'h0004, 26'h0E60004}));
      @(negedge clk);   // EXEC
      @(negedge clk);   // MEM
      // Reset asserted mid-access in MEM of SW
      mem_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_mem_ctrl", 64'(act), 64'd0);
      chk("rst_mem_fields", 64'(fields), 64'd0);
`ifdef MC_PERF_COUNT_EN
      chk("rst_mem_counters", {cycle_count, instr_count}, 64'd0);
`endif
      reset = 1'b0;
      #1;
      chk("post_rst_fetch", 64'(act), 64'(mk(S_F,H,L,L,L,L,P4,L,L,L,A_ADD,5'd0,L,L)));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
